// File: rtl/vscale_src_b_stage_pkg.sv
// Typed views of the shared operand-B select encodings.
`include "vscale_ctrl_constants.vh"

package vscale_src_b_stage_pkg;

    localparam int unsigned SrcBSelW = `SRC_B_SEL_WIDTH;

    typedef logic [SrcBSelW-1:0] src_b_sel_t;

    localparam src_b_sel_t SelRs2  = `SRC_B_RS2;
    localparam src_b_sel_t SelImm  = `SRC_B_IMM;
    localparam src_b_sel_t SelFour = `SRC_B_FOUR;
    localparam src_b_sel_t SelZero = `SRC_B_ZERO;

endpackage

// File: rtl/vscale_byp_select.sv
// Priority bypass matcher: lowest-index valid source whose address matches wins; x0 never hits.
module vscale_byp_select #(
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned XLEN    = 32
) (
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP*REG_AW-1:0] byp_addr,
    input  logic [NUM_BYP*XLEN-1:0]   byp_data,
    output logic                      hit,
    output logic [XLEN-1:0]           data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < int'(NUM_BYP); i++) begin
            if (!hit && byp_valid[i] && (byp_addr[i*REG_AW +: REG_AW] == rs_addr)) begin
                hit  = 1'b1;
                data = byp_data[i*XLEN +: XLEN];
            end
        end
        if (rs_addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/vscale_ctrl_constants.vh
// Shared control encodings for the vscale decode/execute path.
`ifndef VSCALE_CTRL_CONSTANTS_VH
`define VSCALE_CTRL_CONSTANTS_VH

`define XPR_LEN 32

`define SRC_B_SEL_WIDTH 2
`define SRC_B_RS2  2'd0
`define SRC_B_IMM  2'd1
`define SRC_B_FOUR 2'd2
`define SRC_B_ZERO 2'd3

`endif

// File: rtl/vscale_src_b_stage.sv
// Operand-B select with bypass forwarding, registered output plus one skid entry,
// and a saturating backpressure counter.
`include "vscale_ctrl_constants.vh"

module vscale_src_b_stage
    import vscale_src_b_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_BYP   = 2,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned INC_CONST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [`SRC_B_SEL_WIDTH-1:0] src_b_sel,
    input  logic [XLEN-1:0]             imm,
    input  logic [REG_AW-1:0]           rs2_addr,
    input  logic [XLEN-1:0]             rs2_data,
    input  logic [NUM_BYP-1:0]          byp_valid,
    input  logic [NUM_BYP*REG_AW-1:0]   byp_addr,
    input  logic [NUM_BYP*XLEN-1:0]     byp_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             alu_src_b,
    output logic                        fwd_hit,
    output logic [CNT_W-1:0]            stall_cnt,
    input  logic                        cnt_clr
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic            byp_hit;
    logic [XLEN-1:0] byp_val;
    logic [XLEN-1:0] sel_data;
    logic            sel_hit;
    logic            accept;
    logic            out_free;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_hit_q, out_hit_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic            skid_hit_q, skid_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    vscale_byp_select #(
        .NUM_BYP (NUM_BYP),
        .REG_AW  (REG_AW),
        .XLEN    (XLEN)
    ) u_byp_select (
        .rs_addr   (rs2_addr),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .hit       (byp_hit),
        .data      (byp_val)
    );

    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        case (src_b_sel)
            SelRs2: begin
                sel_hit  = byp_hit;
                sel_data = byp_hit ? byp_val : rs2_data;
            end
            SelImm:  sel_data = imm;
            SelFour: sel_data = XLEN'(INC_CONST);
            default: sel_data = '0;
        endcase
    end

    // in_ready comes straight from the skid flop, so it never sees out_ready.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_hit_d    = out_hit_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_hit_d   = skid_hit_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_hit_d    = skid_hit_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_hit_d   = sel_hit;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_hit_d   = sel_hit;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && !out_ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_hit_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_hit_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_hit_q    <= out_hit_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_hit_q   <= skid_hit_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_src_b = out_data_q;
    assign fwd_hit   = out_hit_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_vscale_src_b_stage.sv
// Randomized and directed bench for vscale_src_b_stage against a queue-based reference model.
module tb_vscale_src_b_stage;

    localparam int XLEN = 32;
    localparam int NB   = 2;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid, in_ready;
    logic [1:0]      src_b_sel;
    logic [XLEN-1:0] imm, rs2_data;
    logic [AW-1:0]   rs2_addr;
    logic [NB-1:0]   byp_valid;
    logic [NB*AW-1:0]   byp_addr;
    logic [NB*XLEN-1:0] byp_data;
    logic            flush, out_valid, out_ready, fwd_hit, cnt_clr;
    logic [XLEN-1:0] alu_src_b;
    logic [15:0]     stall_cnt;

    logic            in_valid2, in_ready2, out_valid2, out_ready2, fwd_hit2, cnt_clr2;
    logic [XLEN-1:0] alu_src_b2;
    logic [2:0]      stall_cnt2;

    typedef struct {
        logic [XLEN-1:0] data;
        logic            hit;
    } entry_t;

    entry_t      q[$];
    int unsigned m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    vscale_src_b_stage dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_b_sel(src_b_sel), .imm(imm), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_src_b(alu_src_b),
        .fwd_hit(fwd_hit), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    vscale_src_b_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .src_b_sel(src_b_sel), .imm(imm), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready2), .alu_src_b(alu_src_b2),
        .fwd_hit(fwd_hit2), .stall_cnt(stall_cnt2), .cnt_clr(cnt_clr2)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Operand the spec says should be captured for the current inputs.
    task automatic ref_operand(output entry_t e);
        e.hit  = 1'b0;
        e.data = '0;
        case (src_b_sel)
            2'd0: begin
                e.data = rs2_data;
                if (rs2_addr != 0) begin
                    for (int i = 0; i < NB; i++) begin
                        if (!e.hit && byp_valid[i] && byp_addr[i*AW +: AW] == rs2_addr) begin
                            e.hit  = 1'b1;
                            e.data = byp_data[i*XLEN +: XLEN];
                        end
                    end
                end
            end
            2'd1:    e.data = imm;
            2'd2:    e.data = 32'd4;
            default: e.data = '0;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("in_ready", in_ready, q.size() < 2);
        check_eq("stall_cnt", stall_cnt, m_cnt);
        if (q.size() > 0) begin
            check_eq("alu_src_b", alu_src_b, q[0].data);
            check_eq("fwd_hit", fwd_hit, q[0].hit);
        end
    endtask

    task automatic tick();
        entry_t e;
        bit     acc;
        acc = in_valid && (q.size() < 2);
        ref_operand(e);
        @(posedge clk);
        if (cnt_clr) m_cnt = 0;
        else if (q.size() > 0 && !out_ready && m_cnt < 65535) m_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; src_b_sel = 2'd0; imm = '0; rs2_addr = '0;
        rs2_data = '0; byp_valid = '0; byp_addr = '0; byp_data = '0; flush = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        cnt_clr2 = 1'b0; m_cnt = 0;
        #12 reset_n = 1'b1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_alu_src_b", alu_src_b, 32'h0);
        check_eq("rst_fwd_hit", fwd_hit, 1'b0);
        check_eq("rst_stall_cnt", stall_cnt, 16'h0);

        // Immediate passes through with one cycle latency.
        src_b_sel = 2'd1; imm = 32'h123; in_valid = 1'b1;
        tick();
        check_eq("imm_value", alu_src_b, 32'h123);
        check_eq("imm_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        check_eq("imm_drain", out_valid, 1'b0);

        // Bypass priority and x0 suppression.
        src_b_sel = 2'd0; rs2_addr = 5; rs2_data = 32'h11; in_valid = 1'b1;
        byp_valid = 2'b11; byp_addr = {5'd5, 5'd5}; byp_data = {32'hBB, 32'hAA};
        tick();
        check_eq("byp0_data", alu_src_b, 32'hAA);
        check_eq("byp0_hit", fwd_hit, 1'b1);
        byp_valid = 2'b10;
        tick();
        check_eq("byp1_data", alu_src_b, 32'hBB);
        rs2_addr = 0; rs2_data = 0; byp_addr = '0; byp_valid = 2'b11;
        tick();
        check_eq("x0_data", alu_src_b, 32'h0);
        check_eq("x0_hit", fwd_hit, 1'b0);
        in_valid = 1'b0; byp_valid = '0;
        tick();

        // Backpressure fills the skid entry, then drains in order.
        out_ready = 1'b0; src_b_sel = 2'd1; imm = 32'h1; in_valid = 1'b1;
        tick();
        src_b_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        check_eq("skid_full_ready", in_ready, 1'b0);
        tick();
        tick();
        check_eq("held_a", alu_src_b, 32'h1);
        out_ready = 1'b1;
        tick();
        check_eq("drain_b", alu_src_b, 32'h4);
        check_eq("drain_ready", in_ready, 1'b1);
        tick();

        // Flush with skid full and a request pending.
        out_ready = 1'b0; src_b_sel = 2'd1; in_valid = 1'b1; imm = 32'h10;
        tick();
        imm = 32'h20;
        tick();
        flush = 1'b1; imm = 32'h30;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) tick();

        // Narrow counter saturates, then clear beats increment.
        in_valid2 = 1'b1; out_ready2 = 1'b0;
        tick();
        in_valid2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("sat_cnt", stall_cnt2, (k < 7) ? k : 7);
        end
        cnt_clr2 = 1'b1;
        tick();
        check_eq("sat_clr", stall_cnt2, 3'd0);
        cnt_clr2 = 1'b0;
        tick();
        check_eq("sat_after_clr", stall_cnt2, 3'd1);
        out_ready2 = 1'b1;
        tick();

        // Asynchronous reset while an operand is held.
        out_ready = 1'b0; src_b_sel = 2'd1; imm = 32'h55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_out_valid", out_valid, 1'b0);
        check_eq("async_alu_src_b", alu_src_b, 32'h0);
        check_eq("async_stall_cnt", stall_cnt, 16'h0);
        q.delete();
        m_cnt = 0;
        #3 reset_n = 1'b1;
        out_ready = 1'b1;

        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            src_b_sel = 2'($urandom_range(0, 3));
            rs2_addr  = 5'($urandom_range(0, 3));
            rs2_data  = $urandom;
            imm       = $urandom;
            byp_valid = 2'($urandom_range(0, 3));
            byp_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            byp_data  = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
